// File: rtl/frv_mask_rng_ctrl.sv
// Mask-randomness scheduler: one Galois LFSR shared round-robin between NREQ
// requesters, one fresh word per grant, reseeded from an entropy source.
module frv_mask_rng_ctrl #(
    parameter int              NREQ            = 2,
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] LFSR_TAPS       = 32'hD000_0001,
    parameter int              RESEED_INTERVAL = 1024
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [XLEN-1:0] mask_data,
    input  logic            ent_valid,
    output logic            ent_ready,
    input  logic [XLEN-1:0] ent_data,
    input  logic            force_reseed,
    output logic            reseeding
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(RESEED_INTERVAL + 1);

    // Entropy handshake: a word transfers in any cycle where ent_valid and
    // ent_ready are both high; ent_ready is high only while seeding.
    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESEED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] lfsr_q, lfsr_step, seed_mix, seed_val;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   ptr_q, gnt_idx;
    logic [PW:0]     cand;
    logic            gnt_any, seeding, seed_acc;

    assign seeding   = (state_q != ST_RUN);
    assign ent_ready = g_resetn & seeding;
    assign seed_acc  = ent_ready & ent_valid;
    assign reseeding = seeding;
    assign mask_data = lfsr_q;

    assign lfsr_step = {1'b0, lfsr_q[XLEN-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    assign seed_mix  = lfsr_q ^ ent_data;
    // An all-zero state would lock the LFSR, so it is replaced by 1.
    assign seed_val  = (seed_mix == '0) ? XLEN'(1) : seed_mix;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = '0;
        if (state_q == ST_RUN) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = {1'b0, ptr_q} + (PW+1)'(k);
                if (cand >= (PW+1)'(NREQ)) begin
                    cand = cand - (PW+1)'(NREQ);
                end
                if (!gnt_any && req[cand[PW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[PW-1:0];
                end
            end
        end
    end

    assign gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEED, ST_RESEED: begin
                if (seed_acc) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A grant in the same cycle still completes before reseeding.
                if ((gnt_any && cnt_q == CW'(RESEED_INTERVAL - 1)) || force_reseed) begin
                    state_d = ST_RESEED;
                end
            end
            default: state_d = ST_SEED;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_SEED;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            if (seed_acc) begin
                lfsr_q <= seed_val;
                cnt_q  <= '0;
            end else if (gnt_any) begin
                lfsr_q <= lfsr_step;
                cnt_q  <= cnt_q + CW'(1);
            end
            if (gnt_any) begin
                ptr_q <= gnt_idx;
            end
        end
    end

endmodule
